// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: FSM states, bus event record and shared constants for the banked I2C target
package i2c_target_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;
  typedef struct packed {
    logic start;
    logic stop;
    logic scl_rise;
    logic scl_fall;
  } bus_ev_t;
  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
endpackage

// File: rtl/i2c_glitch_filter.sv
// i2c_glitch_filter: 2-FF synchronizer plus FILTER_LEN-sample agreement filter with edge strobes
module i2c_glitch_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic lvl_q, lvl_d, rise_q, fall_q;
  // the level only moves once the whole history window agrees
  always_comb lvl_d = &hist_q ? 1'b1 : ~|hist_q ? 1'b0 : lvl_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= '1;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      hist_q <= (hist_q << 1) | FILTER_LEN'(sync_q[1]);
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end
  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2c_target_banked.sv
// i2c_target_banked: I2C target answering NUM_ADDR consecutive addresses as register banks; define I2C_TARGET_GENERAL_CALL_EN to accept general-call writes
module i2c_target_banked
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h22,
  parameter int         NUM_ADDR   = 4,
  parameter int         REG_AW     = 4,
  parameter int         FILTER_LEN = 3,
  localparam int        BW         = NUM_ADDR > 1 ? $clog2(NUM_ADDR) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic [BW-1:0]     bank_o,
  output logic [REG_AW-1:0] ptr_o,
  output logic              wr_en_o,
  output logic [7:0]        wr_data_o,
  input  logic [7:0]        rd_data_i,
  output logic              busy_o,
  output logic              nack_o
);
  state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q, wr_data_q;
  logic [BW-1:0] bank_q;
  logic [REG_AW-1:0] ptr_q;
  logic sda_oe_q, wr_en_q, nack_q, busy_q;
  logic scl, sda, scl_r, scl_f, sda_r, sda_f;
  logic [6:0] addr, off;
  logic hit, gc, match;
  bus_ev_t ev;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(scl_i), .lvl_o(scl), .rise_o(scl_r), .fall_o(scl_f)
  );
  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk_i(clk_i), .rst_i(rst_i), .raw_i(sda_i), .lvl_o(sda), .rise_o(sda_r), .fall_o(sda_f)
  );

  assign ev = '{start: sda_f & scl, stop: sda_r & scl, scl_rise: scl_r, scl_fall: scl_f};
  assign addr = sh_q[7:1];
  assign off  = addr - DEV_ADDR;
  assign hit  = addr != GENERAL_CALL_ADDR && addr >= DEV_ADDR && off < 7'(NUM_ADDR);
`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign gc = addr == GENERAL_CALL_ADDR && !sh_q[0];
`else
  assign gc = 1'b0;
`endif
  assign match = hit | gc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      nack_q    <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      bank_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      nack_q  <= 1'b0;
      if (wr_en_q) ptr_q <= ptr_q + 1'b1;
      if (ev.start || ev.stop) begin
        state_q  <= ev.start ? ADDR : IDLE;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ADDR:
            if (ev.scl_rise) begin
              sh_q  <= {sh_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (ev.scl_fall && cnt_q == 4'd8) begin
              state_q  <= match ? ADDR_ACK : IGNORE;
              sda_oe_q <= match;
              busy_q   <= match;
              if (match) bank_q <= gc ? '0 : off[BW-1:0];
            end
          ADDR_ACK:
            if (ev.scl_fall) begin
              cnt_q <= '0;
              if (sh_q[0]) begin
                sh_q     <= rd_data_i;
                ptr_q    <= ptr_q + 1'b1;
                sda_oe_q <= ~rd_data_i[7];
                state_q  <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= PTR;
              end
            end
          PTR, WR_DATA:
            if (ev.scl_rise) begin
              sh_q  <= {sh_q[6:0], sda};
              cnt_q <= cnt_q + 4'd1;
            end else if (ev.scl_fall && cnt_q == 4'd8) begin
              cnt_q    <= '0;
              sda_oe_q <= 1'b1;
              state_q  <= WR_ACK;
              if (state_q == PTR) ptr_q <= sh_q[REG_AW-1:0];
              else begin
                wr_en_q   <= 1'b1;
                wr_data_q <= sh_q;
              end
            end
          WR_ACK:
            if (ev.scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          RD_DATA:
            if (ev.scl_rise) cnt_q <= cnt_q + 4'd1;
            else if (ev.scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sh_q     <= {sh_q[6:0], 1'b0};
                sda_oe_q <= ~sh_q[6];
              end
            end
          RD_ACK:
            if (ev.scl_rise && sda) begin
              nack_q  <= 1'b1;
              state_q <= IGNORE;
            end else if (ev.scl_fall) begin
              cnt_q    <= '0;
              sh_q     <= rd_data_i;
              ptr_q    <= ptr_q + 1'b1;
              sda_oe_q <= ~rd_data_i[7];
              state_q  <= RD_DATA;
            end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o  = sda_oe_q;
  assign bank_o    = bank_q;
  assign ptr_o     = ptr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign nack_o    = nack_q;
endmodule

// File: tb/tb_i2c_target_banked.sv
// tb_i2c_target_banked: directed vector bench for the banked I2C target
`timescale 1ns/1ps
module tb_i2c_target_banked;
  localparam int H = 16;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic scl_i, sda_i, sda_oe_o, wr_en_o, busy_o, nack_o;
  logic [1:0] bank_o;
  logic [3:0] ptr_o;
  logic [7:0] wr_data_o, rd_data_i;
  logic [7:0] mem [16];
  logic [13:0] wr_log [64];
  int n_cmp = 0, n_bad = 0;
  int wr_cnt = 0, nack_cnt = 0, oe_cnt = 0;

  typedef struct {
    logic [6:0] a;
    logic [7:0] p, d0, d1;
    logic       ack;
    logic [1:0] bk;
    int         nw;
    logic [3:0] w0, w1, pf;
  } vec_t;
  vec_t v [6];

  always #5 clk = ~clk;
  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe_o;
  assign rd_data_i = mem[ptr_o];

  i2c_target_banked #(.DEV_ADDR(7'h22), .NUM_ADDR(4), .REG_AW(4), .FILTER_LEN(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .scl_i(scl_i), .sda_i(sda_i), .sda_oe_o(sda_oe_o),
    .bank_o(bank_o), .ptr_o(ptr_o), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
    .rd_data_i(rd_data_i), .busy_o(busy_o), .nack_o(nack_o)
  );

  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_log[wr_cnt[5:0]] <= {bank_o, ptr_o, wr_data_o};
      wr_cnt <= wr_cnt + 1;
    end
    if (nack_o) nack_cnt <= nack_cnt + 1;
    if (sda_oe_o) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_x(logic b, logic g, output logic r);
    sda_m = b;
    tick(H / 2);
    if (g) begin
      scl_m = 1'b1; tick(1); scl_m = 1'b0;
    end
    tick(H / 2);
    scl_m = 1'b1;
    tick(H / 4);
    if (g) begin
      scl_m = 1'b0; tick(1); scl_m = 1'b1; tick(2);
      sda_m = ~b; tick(1); sda_m = b;
    end
    tick(H / 4);
    r = sda_i;
    tick(H / 2);
    scl_m = 1'b0;
    tick(4);
  endtask

  task automatic wr_byte(logic [7:0] d, logic g, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], g, r);
    bit_x(1'b1, g, r);
    ack = ~r;
  endtask

  task automatic rd_byte(logic nak, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_x(nak, 1'b0, r);
  endtask

  task automatic start_c;
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(4);
  endtask

  task automatic stop_c;
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack, r;
    logic [7:0] d;
    int w0c, oe0, n0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[2] = 8'h5A; mem[3] = 8'h6B; mem[9] = 8'h3C;
    v[0] = '{7'h23, 8'h05, 8'hA1, 8'hB2, 1'b1, 2'd1, 2, 4'd5, 4'd6, 4'd7};
    v[1] = '{7'h22, 8'h0F, 8'h11, 8'h22, 1'b1, 2'd0, 2, 4'd15, 4'd0, 4'd1};
    v[2] = '{7'h26, 8'h05, 8'h77, 8'h88, 1'b0, 2'd0, 0, 4'd0, 4'd0, 4'd1};
    v[3] = '{7'h25, 8'h1A, 8'h33, 8'h44, 1'b1, 2'd3, 2, 4'd10, 4'd11, 4'd12};
    v[4] = '{7'h00, 8'h03, 8'h55, 8'h66, 1'b0, 2'd0, 0, 4'd0, 4'd0, 4'd12};
    v[5] = '{7'h21, 8'h03, 8'h55, 8'h66, 1'b0, 2'd0, 0, 4'd0, 4'd0, 4'd12};

    tick(3);
    chk("rst_sda_oe", sda_oe_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_nack", nack_o, 0);
    chk("rst_ptr", ptr_o, 0);
    chk("rst_bank", bank_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    rst_i = 1'b0;
    tick(10);

    for (int k = 0; k < 6; k++) begin
      w0c = wr_cnt;
      oe0 = oe_cnt;
      start_c;
      wr_byte({v[k].a, 1'b0}, 1'b0, ack);
      chk("addr_ack", ack, v[k].ack);
      chk("busy_after_addr", busy_o, v[k].ack);
      wr_byte(v[k].p, 1'b0, ack);
      chk("ptr_ack", ack, v[k].ack);
      wr_byte(v[k].d0, 1'b0, ack);
      chk("d0_ack", ack, v[k].ack);
      wr_byte(v[k].d1, 1'b0, ack);
      chk("d1_ack", ack, v[k].ack);
      stop_c;
      tick(4);
      chk("wr_count", wr_cnt - w0c, v[k].nw);
      if (v[k].nw == 2) begin
        chk("wr_rec0", wr_log[w0c[5:0]], {v[k].bk, v[k].w0, v[k].d0});
        chk("wr_rec1", wr_log[w0c[5:0] + 6'd1], {v[k].bk, v[k].w1, v[k].d1});
      end
      chk("ptr_final", ptr_o, v[k].pf);
      chk("busy_after_stop", busy_o, 0);
      chk("oe_seen", oe_cnt > oe0, v[k].ack);
    end

    w0c = wr_cnt;
    n0 = nack_cnt;
    start_c;
    wr_byte(8'h44, 1'b0, ack);
    chk("rd_waddr_ack", ack, 1);
    wr_byte(8'h02, 1'b0, ack);
    chk("rd_ptr_ack", ack, 1);
    start_c;
    wr_byte(8'h45, 1'b0, ack);
    chk("rd_addr_ack", ack, 1);
    rd_byte(1'b0, d);
    chk("rd_byte0", d, 8'h5A);
    rd_byte(1'b1, d);
    chk("rd_byte1", d, 8'h6B);
    tick(4);
    chk("rd_nack_pulses", nack_cnt - n0, 1);
    chk("rd_ptr_end", ptr_o, 4);
    chk("rd_busy_until_stop", busy_o, 1);
    chk("rd_no_write", wr_cnt - w0c, 0);
    stop_c;
    tick(4);

    w0c = wr_cnt;
    start_c;
    wr_byte(8'h44, 1'b0, ack);
    wr_byte(8'h01, 1'b0, ack);
    chk("part_ptr_ack", ack, 1);
    for (int i = 0; i < 4; i++) bit_x(i[0], 1'b0, r);
    stop_c;
    tick(4);
    chk("part_no_write", wr_cnt - w0c, 0);
    chk("part_busy", busy_o, 0);
    chk("part_sda_oe", sda_oe_o, 0);
    chk("part_ptr", ptr_o, 1);

    w0c = wr_cnt;
    start_c;
    wr_byte(8'h44, 1'b1, ack);
    chk("glitch_addr_ack", ack, 1);
    wr_byte(8'h08, 1'b1, ack);
    chk("glitch_ptr_ack", ack, 1);
    wr_byte(8'h5C, 1'b1, ack);
    chk("glitch_d_ack", ack, 1);
    stop_c;
    tick(4);
    chk("glitch_wr_count", wr_cnt - w0c, 1);
    chk("glitch_wr_rec", wr_log[w0c[5:0]], {2'd0, 4'd8, 8'h5C});
    chk("glitch_ptr", ptr_o, 9);

    start_c;
    wr_byte(8'h45, 1'b0, ack);
    chk("rst_rd_addr_ack", ack, 1);
    tick(6);
    chk("rst_rd_driving", sda_oe_o, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sda_oe", sda_oe_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ptr", ptr_o, 0);
    tick(1);
    rst_i = 1'b0;
    tick(4);
    stop_c;
    tick(4);
    chk("post_rst_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_target_banked.md
I2C_TARGET_BANKED -- requirements
Module: i2c_target_banked

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h22, the base 7-bit target address.
REQ-002 SHALL have parameter NUM_ADDR, default 4, the number of consecutive addresses answered, legal range 1..8.
REQ-003 SHALL have parameter REG_AW, default 4, the register-pointer width; the bank depth is 2^REG_AW.
REQ-004 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal samples needed to accept an SCL/SDA level.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports scl_i and sda_i, inputs, 1 bit each: the raw bus levels, asynchronous to clk_i.
REQ-008 SHALL have port sda_oe_o, output, 1 bit: when 1, the pad pulls SDA low; when 0, SDA is released.
REQ-009 SHALL have ports bank_o (output, $clog2(NUM_ADDR) bits, minimum 1) and ptr_o (output, REG_AW bits): the matched bank and the current register pointer.
REQ-010 SHALL have ports wr_en_o (output, 1 bit), wr_data_o (output, 8 bits) and rd_data_i (input, 8 bits); reads return the data at bank_o/ptr_o.
REQ-011 SHALL have ports busy_o (output, 1 bit: addressed transaction active) and nack_o (output, 1 bit: one-cycle pulse when the controller NACKs a read byte).

Function
REQ-012 SHALL pass scl_i/sda_i through a 2-FF synchronizer followed by the FILTER_LEN filter; all logic SHALL use only the filtered levels and their edge strobes.
REQ-013 SHALL detect START as filtered SDA falling while SCL is high, and STOP as filtered SDA rising while SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-015 SHALL go from any state to ADDR on START, and from any state to IDLE on STOP; sda_oe_o SHALL drop to 0 in the same cycle.
REQ-016 SHALL sample bits on SCL rise, MSB first, and change sda_oe_o only in the cycle after SCL fall is detected.
REQ-017 After 8 address bits SHALL match when addr-DEV_ADDR is in 0..NUM_ADDR-1 (7-bit unsigned, no wrap), latch bank_o, and ACK in ADDR_ACK; otherwise SHALL go to IGNORE with sda_oe_o held at 0 until START or STOP.
REQ-018 On write, the first data byte SHALL load ptr_o with its low REG_AW bits and be ACKed without asserting wr_en_o.
REQ-019 Each following write byte SHALL pulse wr_en_o for one cycle with wr_data_o, at the cycle the ACK is asserted; ptr_o SHALL increment after the pulse.
REQ-020 On read, rd_data_i SHALL be captured into the shift register on the SCL fall ending ADDR_ACK or RD_ACK; ptr_o SHALL increment at capture.
REQ-021 On a read ACK (SDA low) SHALL continue with RD_DATA; on a NACK SHALL pulse nack_o and release SDA until START or STOP.
REQ-022 ptr_o SHALL wrap from 2^REG_AW-1 to 0.
REQ-023 A partial byte cut by START or STOP SHALL be discarded with no wr_en_o pulse.
REQ-024 busy_o SHALL be 1 from an address match until the next START or STOP.

Reset
REQ-025 rst_i SHALL force state IDLE; sda_oe_o, wr_en_o, nack_o and busy_o to 0; ptr_o, bank_o and wr_data_o to 0; synchronizer and filter to 1 (idle bus). This SHALL take effect on the next clk_i edge, including mid-transfer.

Configuration
REQ-026 With macro I2C_TARGET_GENERAL_CALL_EN defined, address 7'h00 with W SHALL be ACKed, with bank_o=0 and following bytes handled as a write; without the macro, 7'h00 SHALL go to IGNORE.

Structure
REQ-027 Package i2c_target_pkg SHALL hold the state enum, the START/STOP/edge event typedef, and the constant GENERAL_CALL_ADDR=7'h00.
REQ-028 Synchronizer and filter SHALL be sub-module i2c_glitch_filter, instantiated once per line.

Verification
REQ-029 Write to 7'h23: ptr byte 8'h05, then 8'hA1, 8'hB2 -> wr_en_o pulses twice with bank_o=1 at ptr 5 and 6; every byte is ACKed.
REQ-030 Write to 7'h22: ptr 8'h0F, then 8'h11, 8'h22 -> writes at ptr 15 then ptr 0 (wrap).
REQ-031 Write of ptr 8'h02, then repeated START, read 7'h22 with rd_data_i=8'h5A then 8'h6B, controller ACKs then NACKs -> SDA carries 5A, 6B; nack_o pulses once; ptr_o=4.
REQ-032 Address 7'h26 (out of range) -> no ACK; sda_oe_o stays 0; busy_o stays 0.
REQ-033 STOP after 4 bits of a data byte -> no wr_en_o pulse; state IDLE.
REQ-034 1-cycle glitches on SCL with FILTER_LEN=3 -> no bit sampled; rst_i mid-read -> sda_oe_o=0 on the next edge.
